if_response_monitor: RTL and testbench
======================================

# if_response_monitor

Downstream observation stage for the intermittent-fault benchmark circuits. Compares a fault-injected circuit instance's primary outputs against a golden instance, sample by sample. Groups mismatches into bursts and queues one event record per burst (start timestamp, mismatch count, bit mask) for the trace/LSTM dataset writer. Keeps a running total of mismatching samples.

## Interface

- WIDTH, 4: number of primary outputs compared (N12..N15 of the 4-output benchmark).
- TS_W, 16: sample timestamp width.
- DUR_W, 8: burst mismatch-count width.
- GAP_MAX, 3: consecutive matching samples that close a burst (legal range 1..15).
- DEPTH, 8: event FIFO depth (power of two).

Ports:

- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- smp_valid  in  1  the dut_resp/gold_resp pair is a valid sample this cycle.
- dut_resp  in  WIDTH  outputs of the fault-injected instance.
- gold_resp  in  WIDTH  outputs of the golden instance.
- clear  in  1  synchronous clear of all state.
- ev_valid  out  1  FIFO head holds an event.
- ev_ready  in  1  consumer accepts the head event.
- ev_ts  out  TS_W  timestamp of the burst's first mismatching sample.
- ev_dur  out  DUR_W  mismatching samples in the burst, saturating.
- ev_mask  out  WIDTH  OR of all XOR vectors in the burst.
- ev_overflow  out  1  sticky: an event was dropped because the FIFO was full.
- mis_count  out  16  total mismatching samples, saturating at 0xFFFF.

## Operation

- **Per valid sample:**
  - x = dut_resp ^ gold_resp.
  - m = |x.
  - The timestamp counter ts (TS_W) increments by 1 and wraps to 0. The sample carries the pre-increment value.
- **FSM IDLE:**
  - Sample with m=1 goes to ACTIVE.
  - Latch start_ts = ts, dur = 1, mask = x, gap = 0.
  - Samples with m=0 stay in IDLE.
- **FSM ACTIVE:**
  - Sample with m=1: dur += 1, saturating at 2^DUR_W-1. mask |= x. gap = 0.
  - Sample with m=0: gap += 1.
  - When gap reaches GAP_MAX: push {start_ts, dur, mask} to the FIFO and return to IDLE.
  - A burst never closes on a mismatching sample.
- **Idle cycles:** cycles with smp_valid=0 change nothing except FIFO pops.
- **mis_count:** increments on every sample with m=1 and holds at 0xFFFF.
- **FIFO:**
  - Show-ahead; ev_* reflect the head entry.
  - Pop occurs when ev_valid && ev_ready.
  - Push when full with no pop that cycle: the event is discarded and ev_overflow is set.
  - Push and pop in the same cycle while full: both succeed; occupancy unchanged; no overflow.
  - Push and pop in the same cycle while empty cannot occur, because the push is registered.
- **clear:**
  - Forces IDLE and empties the FIFO.
  - Zeroes ts, mis_count, ev_overflow and all burst registers.
  - Overrides any sample or pop in the same cycle.
- **ev_* when ev_valid=0:** ev_ts, ev_dur and ev_mask are don't-care but must be stable, not X after reset.

## Timing

- **Reset (rst_n=0, asynchronous):**
  - ev_valid=0, ev_ts=0, ev_dur=0, ev_mask=0, ev_overflow=0, mis_count=0.
  - FSM=IDLE; ts=0; FIFO empty.
- **Reset mid-burst:** the partial burst is discarded and no event is produced.
- **Event latency:** the event is pushed on the clock edge that samples the closing match. ev_valid rises one cycle later if the FIFO was empty.
- **mis_count latency:** updates on the edge that samples the mismatch, visible the next cycle.
- **Handshake rules:**
  - ev_valid may drop only after a pop empties the FIFO.
  - The head fields are stable while ev_valid=1 and ev_ready=0.
- **Throughput:** one sample per cycle, one pop per cycle.

## Test plan

Defaults: GAP_MAX=3, DEPTH=8, smp_valid=1 every cycle.

- **Basic burst:** x=0001 at ts=5, x=0100 at ts=6, matches at ts=7..9 -> exactly one event {ts=5, dur=2, mask=0101}. ev_valid rises the cycle after the ts=9 sample. mis_count=2.
- **Gap below threshold:** mismatch at ts=10, matches at ts=11..12, mismatch x=1000 at ts=13, matches at ts=14..16 -> one event {ts=10, dur=2, mask=…|1000}, not two.
- **Overflow:** ev_ready=0, generate 9 isolated bursts.
  - FIFO holds 8 events; the 9th is dropped; ev_overflow=1.
  - Draining yields the first 8 events in order; ev_overflow stays 1 until clear.
- **Full push+pop:** FIFO full with ev_ready=1 on the cycle a 9th burst closes -> no overflow, occupancy stays 8, and the new event sits at the tail.
- **Saturation:** 300 consecutive mismatching samples, then 3 matches -> ev_dur=255. mis_count=300.
- **Reset and clear:**
  - Assert rst_n=0 mid-burst (dur=4) -> all outputs 0, no event ever emitted; the next burst's ts is counted from 0.
  - Assert clear together with a mismatching sample -> mis_count=0 and FSM=IDLE.

Source files
------------

// File: rtl/if_response_monitor.sv
// if_response_monitor
// Compares a fault-injected instance against a golden instance sample by
// sample, groups mismatching samples into bursts, and queues one event
// record per burst {start_ts, dur, mask} in a show-ahead FIFO. Also keeps a
// saturating count of all mismatching samples.
module if_response_monitor #(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned TS_W    = 16,
   parameter int unsigned DUR_W   = 8,
   parameter int unsigned GAP_MAX = 3,
   parameter int unsigned DEPTH   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             smp_valid,
   input  logic [WIDTH-1:0] dut_resp,
   input  logic [WIDTH-1:0] gold_resp,
   input  logic             clear,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [TS_W-1:0]  ev_ts,
   output logic [DUR_W-1:0] ev_dur,
   output logic [WIDTH-1:0] ev_mask,
   output logic             ev_overflow,
   output logic [15:0]      mis_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned EW = TS_W + DUR_W + WIDTH;
   localparam logic [3:0]  GAP_LIM = 4'(GAP_MAX);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   state_t             r_state;
   state_t             w_state_next;

   logic [TS_W-1:0]    r_ts;
   logic [TS_W-1:0]    r_start_ts;
   logic [DUR_W-1:0]   r_dur;
   logic [WIDTH-1:0]   r_mask;
   logic [3:0]         r_gap;
   logic [15:0]        r_mis;

   logic [EW-1:0]      r_mem [DEPTH];
   logic [PW-1:0]      r_wptr;
   logic [PW-1:0]      r_rptr;
   logic               r_ovf;

   logic [WIDTH-1:0]   w_x;
   logic               w_m;
   logic [3:0]         w_gap_inc;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic [EW-1:0]      w_din;
   logic [EW-1:0]      w_head;

   assign w_x       = dut_resp ^ gold_resp;
   assign w_m       = |w_x;
   assign w_gap_inc = r_gap + 4'd1;

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_pop   = !w_empty && ev_ready && !clear;
   assign w_din   = {r_start_ts, r_dur, r_mask};
   assign w_head  = r_mem[r_rptr[AW-1:0]];

   assign ev_valid              = !w_empty;
   assign {ev_ts, ev_dur, ev_mask} = w_head;
   assign ev_overflow           = r_ovf;
   assign mis_count             = r_mis;

   // Burst FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state decode; a burst closes only on a matching sample that
   // completes GAP_MAX consecutive matches, which also raises the push
   always_comb begin
      w_state_next = r_state;
      w_push       = 1'b0;
      if (clear) begin
         w_state_next = S_IDLE;
      end else if (smp_valid) begin
         case (r_state)
            S_IDLE: begin
               if (w_m) w_state_next = S_ACTIVE;
            end
            S_ACTIVE: begin
               if (!w_m && (w_gap_inc == GAP_LIM)) begin
                  w_state_next = S_IDLE;
                  w_push       = 1'b1;
               end
            end
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // Timestamp, mismatch counter and burst accumulation registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ts       <= '0;
         r_start_ts <= '0;
         r_dur      <= '0;
         r_mask     <= '0;
         r_gap      <= '0;
         r_mis      <= '0;
      end else if (clear) begin
         r_ts       <= '0;
         r_start_ts <= '0;
         r_dur      <= '0;
         r_mask     <= '0;
         r_gap      <= '0;
         r_mis      <= '0;
      end else if (smp_valid) begin
         r_ts <= r_ts + TS_W'(1);
         if (w_m && (r_mis != '1)) r_mis <= r_mis + 16'd1;
         if (r_state == S_IDLE) begin
            if (w_m) begin
               r_start_ts <= r_ts;
               r_dur      <= DUR_W'(1);
               r_mask     <= w_x;
               r_gap      <= '0;
            end
         end else begin
            if (w_m) begin
               if (r_dur != '1) r_dur <= r_dur + DUR_W'(1);
               r_mask <= r_mask | w_x;
               r_gap  <= '0;
            end else begin
               r_gap <= w_push ? 4'd0 : w_gap_inc;
            end
         end
      end
   end

   // Event FIFO; a pop frees the head slot so a push into a full FIFO in
   // the same cycle lands in that slot as the new tail
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (clear) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_ovf  <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         if (w_push) begin
            if (!w_full || w_pop) begin
               r_mem[r_wptr[AW-1:0]] <= w_din;
               r_wptr                <= r_wptr + PW'(1);
            end else begin
               r_ovf <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_response_monitor.sv
// Testbench for if_response_monitor: directed scenarios plus randomized
// traffic, all checked against a behavioural model of bursts and events.
module tb_if_response_monitor;

   localparam int DEPTH = 8;
   localparam int GAP   = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        smp_valid = 1'b0;
   logic [3:0]  dut_resp = '0;
   logic [3:0]  gold_resp = '0;
   logic        clear = 1'b0;
   logic        ev_valid;
   logic        ev_ready = 1'b0;
   logic [15:0] ev_ts;
   logic [7:0]  ev_dur;
   logic [3:0]  ev_mask;
   logic        ev_overflow;
   logic [15:0] mis_count;

   if_response_monitor #(
      .WIDTH  (4),
      .TS_W   (16),
      .DUR_W  (8),
      .GAP_MAX(GAP),
      .DEPTH  (DEPTH)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .smp_valid  (smp_valid),
      .dut_resp   (dut_resp),
      .gold_resp  (gold_resp),
      .clear      (clear),
      .ev_valid   (ev_valid),
      .ev_ready   (ev_ready),
      .ev_ts      (ev_ts),
      .ev_dur     (ev_dur),
      .ev_mask    (ev_mask),
      .ev_overflow(ev_overflow),
      .mis_count  (mis_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int ts;
      int dur;
      int mask;
   } ev_t;

   // Behavioural model: sample counter, open burst description, event queue
   ev_t q[$];
   int  m_ts, m_mis, m_start, m_dur, m_mask, m_gap;
   bit  m_open, m_ovf;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ts = 0; m_mis = 0; m_start = 0; m_dur = 0; m_mask = 0; m_gap = 0;
      m_open = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic compare_all();
      check_eq("ev_valid", 32'(ev_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check_eq("ev_ts", 32'(ev_ts), q[0].ts);
         check_eq("ev_dur", 32'(ev_dur), q[0].dur);
         check_eq("ev_mask", 32'(ev_mask), q[0].mask);
      end
      check_eq("ev_overflow", 32'(ev_overflow), 32'(m_ovf));
      check_eq("mis_count", 32'(mis_count), m_mis);
   endtask

   // One clock: drive inputs, advance the model, check just after the edge
   task automatic cycle(input bit v, input logic [3:0] x, input bit rdy, input bit clr);
      logic [3:0] g;
      ev_t        e;
      g         = 4'($urandom());
      smp_valid = v;
      gold_resp = g;
      dut_resp  = g ^ x;
      ev_ready  = rdy;
      clear     = clr;
      if (clr) begin
         model_reset();
      end else begin
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (v) begin
            int ts_s;
            ts_s = m_ts;
            m_ts = (m_ts + 1) % 65536;
            if (x != 0 && m_mis < 65535) m_mis++;
            if (!m_open) begin
               if (x != 0) begin
                  m_open = 1'b1; m_start = ts_s; m_dur = 1; m_mask = int'(x); m_gap = 0;
               end
            end else if (x != 0) begin
               m_dur  = (m_dur < 255) ? m_dur + 1 : 255;
               m_mask = m_mask | int'(x);
               m_gap  = 0;
            end else begin
               m_gap++;
               if (m_gap == GAP) begin
                  e.ts = m_start; e.dur = m_dur; e.mask = m_mask;
                  if (q.size() < DEPTH) q.push_back(e);
                  else m_ovf = 1'b1;
                  m_open = 1'b0;
               end
            end
         end
      end
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, 32'(ev_valid), 32'd0);
      check_eq({tag, "_ts"}, 32'(ev_ts), 32'd0);
      check_eq({tag, "_dur"}, 32'(ev_dur), 32'd0);
      check_eq({tag, "_mask"}, 32'(ev_mask), 32'd0);
      check_eq({tag, "_ovf"}, 32'(ev_overflow), 32'd0);
      check_eq({tag, "_mis"}, 32'(mis_count), 32'd0);
   endtask

   task automatic burst(input bit rdy);
      logic [3:0] x;
      x = 4'($urandom_range(1, 15));
      cycle(1'b1, x, rdy, 1'b0);
      for (int i = 0; i < GAP; i++) cycle(1'b1, 4'h0, rdy, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
   endtask

   initial begin
      model_reset();
      #12;
      check_reset_outputs("reset");
      rst_n = 1'b1;

      // Basic burst: x=0001 at ts=5, x=0100 at ts=6, matches ts=7..9
      for (int i = 0; i < 5; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 4'h1, 1'b0, 1'b0);
      cycle(1'b1, 4'h4, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 1'b0, 1'b0);
      check_eq("basic_not_yet", 32'(ev_valid), 32'd0);
      cycle(1'b1, 4'h0, 1'b0, 1'b0);
      check_eq("basic_valid", 32'(ev_valid), 32'd1);
      check_eq("basic_ts", 32'(ev_ts), 32'd5);
      check_eq("basic_dur", 32'(ev_dur), 32'd2);
      check_eq("basic_mask", 32'(ev_mask), 32'h5);
      check_eq("basic_mis", 32'(mis_count), 32'd2);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);

      // Gap below threshold keeps one burst
      cycle(1'b1, 4'h2, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 4'h8, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0);
      check_eq("gap_ts", 32'(ev_ts), 32'd10);
      check_eq("gap_dur", 32'(ev_dur), 32'd2);
      check_eq("gap_mask", 32'(ev_mask), 32'hA);
      cycle(1'b0, 4'h0, 1'b1, 1'b0);
      check_eq("gap_single", 32'(ev_valid), 32'd0);

      // Overflow: 9 bursts into 8 entries, then drain
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      for (int b = 0; b < 9; b++) burst(1'b0);
      check_eq("ovf_set", 32'(ev_overflow), 32'd1);
      drain();
      check_eq("ovf_sticky", 32'(ev_overflow), 32'd1);

      // Full FIFO with pop on the cycle a 9th burst closes
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      for (int b = 0; b < 8; b++) burst(1'b0);
      cycle(1'b1, 4'h3, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 1'b0, 1'b0);
      cycle(1'b1, 4'h0, 1'b1, 1'b0);
      check_eq("fullpp_ovf", 32'(ev_overflow), 32'd0);
      check_eq("fullpp_occ", 32'(q.size()), 32'd8);
      drain();

      // Saturation of dur
      cycle(1'b0, 4'h0, 1'b0, 1'b1);
      for (int i = 0; i < 300; i++) cycle(1'b1, 4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0);
      check_eq("sat_dur", 32'(ev_dur), 32'd255);
      check_eq("sat_mis", 32'(mis_count), 32'd300);
      drain();

      // Asynchronous reset mid-burst
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'h6, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0);
      check_eq("midrst_noev", 32'(ev_valid), 32'd0);
      cycle(1'b1, 4'h0, 1'b0, 1'b1);
      cycle(1'b1, 4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0);
      check_eq("midrst_ts0", 32'(ev_ts), 32'd0);
      drain();

      // Clear together with a mismatching sample
      cycle(1'b1, 4'h4, 1'b0, 1'b0);
      cycle(1'b1, 4'h4, 1'b0, 1'b1);
      check_eq("clr_mis", 32'(mis_count), 32'd0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'h0, 1'b0, 1'b0);
      check_eq("clr_idle", 32'(ev_valid), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit         v, r, c;
         logic [3:0] x;
         v = ($urandom_range(0, 9) != 0);
         x = ($urandom_range(0, 2) == 0) ? 4'($urandom()) : 4'h0;
         r = ($urandom_range(0, 3) == 0);
         c = ($urandom_range(0, 499) == 0);
         cycle(v, x, r, c);
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
